// File: rtl/led_blink_ctrl_if.sv
// Command channel for led_blink_ctrl: valid/ready handshake plus blink parameters.
// The master (user logic) drives the command; the slave (controller) returns ready.
interface led_blink_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_count;
    logic [7:0] cmd_on;
    logic [7:0] cmd_off;

    modport master (
        output cmd_valid,
        output cmd_count,
        output cmd_on,
        output cmd_off,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_count,
        input  cmd_on,
        input  cmd_off,
        output cmd_ready
    );
endinterface

// File: rtl/led_blink_ctrl.sv
// Command-driven LED blink sequencer: N on/off pulses timed by a tick prescaler, then done.
// Optional pause input enabled by defining LED_BLINK_CTRL_PAUSE_EN.
module led_blink_ctrl #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    led_blink_ctrl_if.slave        cmd_if,
    input  logic                   abort_i,
`ifdef LED_BLINK_CTRL_PAUSE_EN
    input  logic                   pause_i,
`endif
    output logic                   led_o,
    output logic                   led_probe_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned PresW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PresW-1:0] PresMax = PresW'(PRESCALE - 1);

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

    state_e           state_q;
    logic [PresW-1:0] presc_q;
    logic [7:0]       tick_cnt_q;
    logic [7:0]       on_len_q;
    logic [7:0]       off_len_q;
    logic [3:0]       remaining_q;
    logic             continuous_q;
    logic             led_q;
    logic             busy_q;
    logic             done_q;

    logic             hold;
    logic             accept;
    logic             tick;
    logic [7:0]       tick_cnt_inc;

`ifdef LED_BLINK_CTRL_PAUSE_EN
    assign hold = pause_i;
`else
    assign hold = 1'b0;
`endif

    assign cmd_if.cmd_ready = (state_q == StIdle) && !abort_i;
    assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign tick             = (state_q != StIdle) && !hold && (presc_q == PresMax);
    assign tick_cnt_inc     = tick_cnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            tick_cnt_q   <= '0;
            on_len_q     <= '0;
            off_len_q    <= '0;
            remaining_q  <= '0;
            continuous_q <= 1'b0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                // Abort wins over everything, including pause; the command is discarded.
                state_q      <= StIdle;
                presc_q      <= '0;
                tick_cnt_q   <= '0;
                on_len_q     <= '0;
                off_len_q    <= '0;
                remaining_q  <= '0;
                continuous_q <= 1'b0;
                led_q        <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (accept) begin
                            on_len_q     <= (cmd_if.cmd_on == 8'd0) ? 8'd1 : cmd_if.cmd_on;
                            off_len_q    <= (cmd_if.cmd_off == 8'd0) ? 8'd1 : cmd_if.cmd_off;
                            remaining_q  <= cmd_if.cmd_count;
                            continuous_q <= (cmd_if.cmd_count == 4'd0);
                            presc_q      <= '0;
                            tick_cnt_q   <= '0;
                            state_q      <= StOn;
                            led_q        <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                    StOn: begin
                        if (tick) begin
                            presc_q <= '0;
                            if (tick_cnt_inc == on_len_q) begin
                                tick_cnt_q <= '0;
                                state_q    <= StOff;
                                led_q      <= 1'b0;
                            end else begin
                                tick_cnt_q <= tick_cnt_inc;
                            end
                        end else if (!hold) begin
                            presc_q <= presc_q + PresW'(1);
                        end
                    end
                    StOff: begin
                        if (tick) begin
                            presc_q <= '0;
                            if (tick_cnt_inc == off_len_q) begin
                                tick_cnt_q <= '0;
                                if (continuous_q || (remaining_q > 4'd1)) begin
                                    if (!continuous_q) begin
                                        remaining_q <= remaining_q - 4'd1;
                                    end
                                    state_q <= StOn;
                                    led_q   <= 1'b1;
                                end else begin
                                    remaining_q <= '0;
                                    state_q     <= StIdle;
                                    busy_q      <= 1'b0;
                                    done_q      <= 1'b1;
                                end
                            end else begin
                                tick_cnt_q <= tick_cnt_inc;
                            end
                        end else if (!hold) begin
                            presc_q <= presc_q + PresW'(1);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign led_o       = led_q;
    assign led_probe_o = led_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed self-checking bench for led_blink_ctrl with PRESCALE=4.
// Pause scenarios are compiled in when LED_BLINK_CTRL_PAUSE_EN is defined.
module tb_led_blink_ctrl;

    localparam int P = 4;

    logic clk;
    logic rst;
    logic abort;
    logic pause;
    logic led;
    logic led_probe;
    logic busy;
    logic done;

    int checks;
    int errors;

    led_blink_ctrl_if cmd_if ();

    led_blink_ctrl #(
        .PRESCALE (P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_if      (cmd_if),
        .abort_i     (abort),
`ifdef LED_BLINK_CTRL_PAUSE_EN
        .pause_i     (pause),
`endif
        .led_o       (led),
        .led_probe_o (led_probe),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] cnt, input logic [7:0] on_t, input logic [7:0] off_t);
        cmd_if.cmd_count = cnt;
        cmd_if.cmd_on    = on_t;
        cmd_if.cmd_off   = off_t;
        cmd_if.cmd_valid = 1'b1;
        #1;
        chk("issue_ready", 32'(cmd_if.cmd_ready), 32'd1);
        step();
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Checks a finite run cycle by cycle from the cycle after accept; returns at the done cycle.
    task automatic run_check(input int on_t, input int off_t, input int n, input string tag);
        int period;
        int total;
        logic exp_led;
        period = (on_t + off_t) * P;
        total  = n * period;
        for (int c = 0; c < total; c++) begin
            exp_led = ((c % period) < on_t * P);
            chk({tag, "_led"}, 32'(led), 32'(exp_led));
            chk({tag, "_probe"}, 32'(led_probe), 32'(exp_led));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_done"}, 32'(done), 32'd0);
            step();
        end
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_led"}, 32'(led), 32'd0);
        chk({tag, "_done_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        abort            = 1'b0;
        pause            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_count = '0;
        cmd_if.cmd_on    = '0;
        cmd_if.cmd_off   = '0;
        step();
        step();
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_probe", 32'(led_probe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        rst = 1'b0;
        step();

        // Reset asserted mid-ON forces idle outputs without waiting for an edge.
        issue(4'd2, 8'd3, 8'd2);
        step();
        step();
        chk("midon_led", 32'(led), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_led", 32'(led), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        step();
        rst = 1'b0;
        step();

        // Basic: 2 x (12 on, 8 off), done 40 cycles after accept.
        issue(4'd2, 8'd3, 8'd2);
        run_check(3, 2, 2, "basic");
        chk_done("basic");
        step();
        chk("basic_done_once", 32'(done), 32'd0);

        // Zero on/off lengths behave as 1 tick each.
        issue(4'd1, 8'd0, 8'd0);
        run_check(1, 1, 1, "zero");
        chk_done("zero");
        step();

        // Valid held through a sequence: ignored while busy, accepted at the done edge.
        cmd_if.cmd_count = 4'd1;
        cmd_if.cmd_on    = 8'd1;
        cmd_if.cmd_off   = 8'd1;
        cmd_if.cmd_valid = 1'b1;
        step();
        cmd_if.cmd_on    = 8'd2;
        cmd_if.cmd_count = 4'd3;
        run_check(1, 1, 1, "held_a");
        chk_done("held_a");
        cmd_if.cmd_count = 4'd1;
        step();
        cmd_if.cmd_valid = 1'b0;
        run_check(2, 1, 1, "held_b");
        chk_done("held_b");
        step();

        // Continuous: toggles every 4 cycles with no done, then abort.
        issue(4'd0, 8'd1, 8'd1);
        for (int c = 0; c < 120; c++) begin
            chk("cont_led", 32'(led), 32'((c % 8) < 4));
            chk("cont_done", 32'(done), 32'd0);
            step();
        end
        chk("cont_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        step();
        chk("abort_led", 32'(led), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);

        // Abort with valid in IDLE blocks acceptance.
        cmd_if.cmd_count = 4'd1;
        cmd_if.cmd_on    = 8'd1;
        cmd_if.cmd_off   = 8'd1;
        cmd_if.cmd_valid = 1'b1;
        #1;
        chk("abort_ready", 32'(cmd_if.cmd_ready), 32'd0);
        step();
        chk("abort_noacc_busy", 32'(busy), 32'd0);
        chk("abort_noacc_led", 32'(led), 32'd0);
        cmd_if.cmd_valid = 1'b0;
        abort = 1'b0;
        step();
        chk("abort_nodone", 32'(done), 32'd0);
        chk("post_abort_ready", 32'(cmd_if.cmd_ready), 32'd1);

`ifdef LED_BLINK_CTRL_PAUSE_EN
        // Pause of 10 cycles during a 12-cycle ON phase stretches it to 22.
        issue(4'd1, 8'd3, 8'd1);
        repeat (5) step();
        pause = 1'b1;
        repeat (10) step();
        pause = 1'b0;
        chk("pause_led_held", 32'(led), 32'd1);
        repeat (6) step();
        chk("pause_led_c21", 32'(led), 32'd1);
        step();
        chk("pause_led_c22", 32'(led), 32'd0);
        chk("pause_busy_c22", 32'(busy), 32'd1);
        pause = 1'b1;
        abort = 1'b1;
        step();
        chk("pause_abort_busy", 32'(busy), 32'd0);
        chk("pause_abort_led", 32'(led), 32'd0);
        chk("pause_abort_done", 32'(done), 32'd0);
        pause = 1'b0;
        abort = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_blink_ctrl.md
# led_blink_ctrl

Command-driven LED blink sequencer for the practicum boards. It accepts a blink command over a valid/ready handshake, produces an exact number of on/off pulses timed by an internal tick prescaler, and then reports completion. It sits between user logic (FSM or switch decoder) and the on-board LED pin, and replaces the bare free-running-counter blinker. A debug probe copy of the LED drive is also provided.

## Interface
- PRESCALE, 100000 — clock cycles per tick; 1 kHz tick at 100 MHz; legal range 2..2^24.
- clk  in  1  system clock, 100 MHz on-board oscillator.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_count  in  4  number of blinks; 0 = continuous until abort.
- cmd_on  in  8  on time in ticks; 0 is treated as 1.
- cmd_off  in  8  off time in ticks; 0 is treated as 1.
- abort  in  1  stop the current sequence immediately.
- LED  out  1  LED drive, registered.
- LED_probe  out  1  copy of LED for oscilloscope probing on a GPIO pin.
- busy  out  1  high while a sequence runs.
- done  out  1  one-cycle pulse when a finite sequence completes.
- pause  in  1  present only with LED_BLINK_CTRL_PAUSE_EN; freezes the sequence.

## Operation
- FSM states: IDLE, ON, OFF. Reset and abort both lead to IDLE.
- cmd_ready = (state == IDLE) && !abort. This is combinational.
- Accept occurs when cmd_valid && cmd_ready are high at a rising edge. On accept:
  - latch on_len = max(cmd_on, 1), off_len = max(cmd_off, 1) and remaining = cmd_count;
  - set continuous = (cmd_count == 0);
  - clear the prescaler and tick counter;
  - go to ON.
- Prescaler: counts 0..PRESCALE-1 while in ON or OFF. A tick fires when the count equals PRESCALE-1; the count then wraps to 0.
- Tick counter (8-bit): increments on each tick.
  - ON → OFF when a tick brings it to on_len. The counter clears.
  - OFF → ON when a tick brings it to off_len, provided continuous is set or remaining > 1. On that transition, remaining decrements unless continuous is set, and the counter clears.
  - OFF → IDLE when a tick brings it to off_len, continuous is clear and remaining == 1. done pulses in the same cycle that IDLE is entered.
- LED = 1 only in ON. busy = (state != IDLE).
- abort: highest priority in every state. The next edge goes to IDLE with LED=0 and busy=0. No done pulse is generated, and the latched command is discarded.
- cmd_valid outside IDLE is ignored. The command is not queued.

## Timing
- Reset values: LED=0, LED_probe=0, busy=0, done=0, cmd_ready=1 (abort low), state IDLE, all counters 0.
- LED and busy rise in the cycle after the accept edge.
- ON lasts exactly on_len×PRESCALE cycles. OFF lasts exactly off_len×PRESCALE cycles.
- Total finite-sequence duration: accept edge to done pulse = N×(on_len+off_len)×PRESCALE cycles.
- cmd_ready returns high in the same cycle done pulses. A new command can be accepted at that edge, so back-to-back sequences have zero gap.
- Abort takes effect at the first edge it is sampled high. Reset asserted mid-sequence forces the reset values immediately.
- Counters stay within their widths. No arithmetic overflow is possible, given the 8-bit on/off lengths and the bounded PRESCALE.

## Configuration
- LED_BLINK_CTRL_PAUSE_EN defined:
  - the pause port exists;
  - while pause=1, the prescaler, tick counter, state and LED hold their values;
  - abort and reset still act;
  - accept in IDLE is still allowed, and timing for the new command starts when pause is released.
- Not defined: there is no pause port, and the sequence always advances.

## Test plan
All scenarios use PRESCALE=4.
- Reset value check: assert rst mid-ON (count=2, on=3, off=2) → LED, busy, done = 0 and cmd_ready=1 immediately; the next command runs normally.
- Basic sequence: count=2, on=3, off=2 → LED high for 12 cycles, low 8, high 12, low 8. done pulses once, 40 cycles after accept. busy falls at the same time.
- Zero-length fields: on=0, off=0, count=1 → LED high 4 cycles, low 4 cycles, then done.
- Continuous mode: count=0, on=1, off=1 → LED toggles every 4 cycles for at least 100 cycles with no done. abort → LED=0 and busy=0 at the next edge, no done.
- Handshake rules:
  - cmd_valid while busy → ignored; the sequence is unchanged.
  - cmd_valid held through the done cycle → the second command is accepted at the done edge, and LED rises on the next cycle.
  - abort and cmd_valid together in IDLE → not accepted.
- With LED_BLINK_CTRL_PAUSE_EN: pause for 10 cycles during ON (on=3) → that ON phase lasts 22 cycles; abort during pause → IDLE at the next edge.
